// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor.
// Adds or subtracts two WIDTH-bit operands DIGIT bits per cycle, least significant digit first,
// under a valid/ready handshake on both sides. The result is presented with its carry out in the
// top bit; for subtraction a set carry means no borrow.
// Optional build macro: DIGIT_SERIAL_ADDER_OVF_EN adds the signed-overflow output 'ovf'.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   o
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH:0]   o_q, o_d;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] res_shift;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
    logic             msb_cin;
`endif

    // Digit adder: low DIGIT bits of both operands plus the running carry.
    always_comb begin
        dsum      = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        // New digit enters at the MSB end so the last digit lands in the top position.
        res_shift = (res_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        // Carry into the operand MSB recovered from the MSB sum bit of the final digit.
        msb_cin   = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ dsum[DIGIT-1];
`endif
    end

    // Next-state and datapath update; everything holds unless the current state acts.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        o_d     = o_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    // Subtraction as a + ~b + 1: invert b, seed carry with sub.
                    opa_d   = a;
                    opb_d   = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                carry_d = dsum[DIGIT];
                res_d   = res_shift;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    // Result register only changes here, so o is stable outside RUN->DONE.
                    o_d     = {dsum[DIGIT], res_shift};
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                    ovf_d   = msb_cin ^ dsum[DIGIT];
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            o_q     <= '0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            o_q     <= o_d;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshake outputs decoded from state; in_ready is masked while reset is held.
    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StDone);
        o         = o_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Testbench for digit_serial_adder: a DIGIT=1 and a DIGIT=4 instance (WIDTH=8) share stimulus.
// Honours DIGIT_SERIAL_ADDER_OVF_EN to also check the overflow flag.
module tb_digit_serial_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       out_ready;
    logic       in_ready1, in_ready4;
    logic       out_valid1, out_valid4;
    logic [8:0] o1, o4;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic       ovf1, ovf4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .o         (o1)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .o         (o4)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [8:0] exp;
        logic       ovf;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [8:0] model_o(input int ua, input int ub, input bit s);
        int r;
        if (s) r = ((ua - ub) & 255) | ((ua >= ub) ? 256 : 0);
        else   r = ua + ub;
        return 9'(r);
    endfunction

    function automatic logic model_ovf(input int ua, input int ub, input bit s);
        int sa, sb, r;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        r  = s ? sa - sb : sa + sb;
        return (r > 127) || (r < -128);
    endfunction

    // Ends on a negedge with both instances ready.
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready1 && in_ready4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: in_ready1=%0b in_ready4=%0b, expected both 1",
                     in_ready1, in_ready4);
        end
    endtask

    // One transaction; latency counted in edges after the accepting edge (-1 = never).
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                         output logic [8:0] r1, output logic [8:0] r4,
                         output logic f1, output logic f4,
                         output int l1, output int l4);
        r1 = '0; r4 = '0; f1 = 1'b0; f4 = 1'b0; l1 = -1; l4 = -1;
        wait_idle();
        a = ta; b = tb; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operand changes during RUN must not matter.
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (out_valid1 && l1 < 0) begin
                l1 = e; r1 = o1;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                f1 = ovf1;
`endif
            end
            if (out_valid4 && l4 < 0) begin
                l4 = e; r4 = o4;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                f4 = ovf4;
`endif
            end
            if (l1 >= 0 && l4 >= 0) break;
        end
    endtask

    task automatic op_check(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                            input logic ts, input logic [8:0] exp, input logic eovf);
        logic [8:0] r1, r4;
        logic       f1, f4;
        int         l1, l4;
        do_op(ta, tb, ts, r1, r4, f1, f4, l1, l4);
        check({tag, "_o_d1"}, 32'(r1), 32'(exp));
        check({tag, "_o_d4"}, 32'(r4), 32'(exp));
        check({tag, "_lat_d1"}, l1, 8);
        check({tag, "_lat_d4"}, l4, 2);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        check({tag, "_ovf_d1"}, 32'(f1), 32'(eovf));
        check({tag, "_ovf_d4"}, 32'(f4), 32'(eovf));
`else
        if (eovf === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rs;
        bit         seen;

        vecs[0]  = '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
        vecs[1]  = '{8'h05, 8'h07, 1'b1, 9'h0FE, 1'b0};
        vecs[2]  = '{8'h07, 8'h05, 1'b1, 9'h102, 1'b0};
        vecs[3]  = '{8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b0};
        vecs[4]  = '{8'h00, 8'h00, 1'b0, 9'h000, 1'b0};
        vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 9'h100, 1'b0};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 9'h100, 1'b0};
        vecs[8]  = '{8'h00, 8'h01, 1'b1, 9'h0FF, 1'b0};
        vecs[9]  = '{8'h12, 8'h34, 1'b0, 9'h046, 1'b0};
        vecs[10] = '{8'h80, 8'h01, 1'b1, 9'h17F, 1'b1};
        vecs[11] = '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1};
        vecs[12] = '{8'h10, 8'h20, 1'b0, 9'h030, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_held", 32'(in_ready1), 0);
        rst = 1'b0;
        #1;
        check("rst_o", 32'(o1), 0);
        check("rst_out_valid", 32'(out_valid1), 0);
        check("rst_in_ready", 32'(in_ready1), 1);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf1), 0);
`endif

        for (int i = 0; i < 13; i++) begin
            op_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                     vecs[i].exp, vecs[i].ovf);
        end

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            op_check($sformatf("rnd%0d", i), ra, rb, rs, model_o(int'(ra), int'(rb), rs),
                     model_ovf(int'(ra), int'(rb), rs));
        end

        // Back-pressure: hold DONE with in_valid high and different operands presented.
        wait_idle();
        a = 8'h3C; b = 8'h0F; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        a = 8'h11; b = 8'h22; sub = 1'b1;
        seen = 1'b0;
        for (int e = 0; e < 20; e++) begin
            if (out_valid1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("bp_reached_done", 32'(seen), 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_o_c%0d", c), 32'(o1), 32'h04B);
            check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready1), 0);
            check($sformatf("bp_out_valid_c%0d", c), 32'(out_valid1), 1);
            check($sformatf("bp_o4_c%0d", c), 32'(o4), 32'h04B);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_exit_out_valid", 32'(out_valid1), 0);
        check("bp_exit_in_ready", 32'(in_ready1), 1);
        check("bp_exit_o_held", 32'(o1), 32'h04B);
        op_check("bp_next", 8'h01, 8'h02, 1'b0, 9'h003, 1'b0);

        // Reset in the middle of an 8-digit run.
        wait_idle();
        a = 8'h55; b = 8'h0A; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_o", 32'(o1), 0);
        check("mid_rst_o4", 32'(o4), 0);
        check("mid_rst_out_valid", 32'(out_valid1), 0);
        check("mid_rst_in_ready", 32'(in_ready1), 1);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid1) seen = 1'b1;
        end
        check("mid_rst_no_result", 32'(seen), 0);
        op_check("mid_rst_next", 8'h12, 8'h34, 1'b0, 9'h046, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Overall time bound so the bench always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (>=2).
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per cycle; WIDTH % DIGIT == 0.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands and mode presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port o  output  WIDTH+1  result; o[WIDTH] = carry out (for sub: 1 = no borrow).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-014 SHALL drive in_ready = 1 only in IDLE with rst low; out_valid = 1 only in DONE.
REQ-015 SHALL accept on the edge with in_valid & in_ready: capture a, b XOR {WIDTH{sub}}, carry = sub, digit counter = 0, go to RUN.
REQ-016 SHALL, each RUN cycle, add the low DIGIT bits of both captured operands plus carry, shift the DIGIT-bit sum into the result register from the MSB side, shift operands right by DIGIT, and update carry.
REQ-017 SHALL leave RUN for DONE on the edge completing digit N-1; out_valid rises exactly N edges after the accepting edge.
REQ-018 SHALL, in DONE, hold o stable, with o[WIDTH] = final carry, until the edge with out_ready = 1, then go to IDLE.
REQ-019 SHALL ignore in_valid, a, b and sub in RUN and DONE; no bypass from DONE to RUN in the same edge.
REQ-020 SHALL accept in_valid in the cycle after DONE exits (minimum initiation interval N+2 cycles).
REQ-021 SHALL compute o[WIDTH-1:0] = (a + b) mod 2^WIDTH or (a - b) mod 2^WIDTH, bit-exact for all operand values including all-zeros and all-ones.
REQ-022 SHALL keep o unchanged from the DONE exit until the next DONE entry.

Reset
REQ-023 SHALL, on rst = 1 at a clock edge, enter IDLE, clear o, carry, counter and captured operands, and force out_valid = 0.
REQ-024 SHALL abandon any RUN or DONE operation on reset, never presenting its result.
REQ-025 SHALL assert in_ready in the first cycle with rst low after reset.

Configuration
REQ-026 SHALL, with macro DIGIT_SERIAL_ADDER_OVF_EN defined, add port ovf  output  1, the signed two's-complement overflow flag (carry into MSB XOR carry out of MSB of the effective addition), valid with out_valid and reset to 0.
REQ-027 SHALL, without DIGIT_SERIAL_ADDER_OVF_EN, have no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover WIDTH=8, DIGIT=1, a=0xFF, b=0x01, sub=0 -> out_valid 8 edges after accept, o=0x100.
REQ-029 SHALL cover WIDTH=8, DIGIT=1, a=0x05, b=0x07, sub=1 -> o=0x0FE (o[8]=0, borrow); a=0x07, b=0x05 -> o=0x102.
REQ-030 SHALL cover WIDTH=8, DIGIT=4, a=0x3C, b=0x0F, sub=0 -> out_valid 2 edges after accept, o=0x04B.
REQ-031 SHALL cover back-pressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> o stable, in_ready=0, no new capture; out_ready=1 -> IDLE next edge.
REQ-032 SHALL cover reset at RUN digit 3 of an 8-digit operation -> out_valid never rises for it, o=0, in_ready=1 after release, next operation 0x12+0x34 -> o=0x046.
REQ-033 SHALL cover, with DIGIT_SERIAL_ADDER_OVF_EN, 0x7F+0x01 -> ovf=1; 0x80-0x01 -> ovf=1; 0x10+0x20 -> ovf=0.
